serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand/result bit width (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  rising-edge clock; single clock domain.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin subtraction a - b.
REQ-005 SHALL have port: a  input  WIDTH  minuend; sampled only on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend; sampled only on accepted start.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-009 SHALL have port: diff  output  WIDTH  result a - b mod 2^WIDTH.
REQ-010 SHALL have port: b_out  output  1  borrow out; 1 iff a < b unsigned.

Function
REQ-011 SHALL implement a 1-bit full-adder datapath computing a + ~b + 1, one bit per cycle, LSB first; carry register preset to 1 at start.
REQ-012 SHALL use FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL load a, ~b into shift registers, clear bit counter, go to RUN.
REQ-014 RUN: each edge SHALL process one bit, shift result in at MSB, increment counter; after WIDTH bits SHALL go to DONE.
REQ-015 DONE: SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-016 Latency: start sampled at edge k -> done high in cycle after edge k+WIDTH (k+4 for WIDTH=4).
REQ-017 busy SHALL be high in RUN only; busy and done SHALL never be high together.
REQ-018 start in RUN or DONE SHALL be ignored; no queuing; a/b changes while busy SHALL not affect the result.
REQ-019 diff and b_out SHALL update only on the edge entering DONE and hold until the next completion.
REQ-020 b_out SHALL equal the inverted final carry.
REQ-021 Back-to-back: start held high SHALL be accepted in the first IDLE cycle after DONE (throughput one result per WIDTH+2 cycles).

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, busy=0, done=0, diff=0, b_out=0, counter=0, carry=1; overrides start.
REQ-023 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-024 After rst release, the first start SHALL be accepted normally.

Configuration
REQ-025 Macro SERIAL_SUB_FLAGS_EN, when defined, SHALL add outputs zero (1 bit, diff==0) and ovf (1 bit, signed overflow: a[MSB]!=b[MSB] and diff[MSB]!=a[MSB]).
REQ-026 With SERIAL_SUB_FLAGS_EN, zero and ovf SHALL update with diff, reset to 0, and hold likewise.
REQ-027 Without SERIAL_SUB_FLAGS_EN, zero and ovf SHALL not exist; all other behaviour identical.

Verification (WIDTH=4)
REQ-028 a=7, b=3, start one cycle -> done 4 edges after start edge, diff=4, b_out=0, busy high exactly 4 cycles.
REQ-029 a=3, b=7 -> diff=0xC, b_out=1, ovf=0, zero=0.
REQ-030 a=7, b=8 -> diff=0xF, b_out=1, ovf=1; a=5, b=5 -> diff=0, b_out=0, zero=1.
REQ-031 Start a=9,b=2; pulse start with a=1,b=1 on 2nd RUN cycle -> single done, diff=7; no second done.
REQ-032 Start, assert rst on 3rd RUN cycle -> busy=0, done never pulses, diff=0, b_out=0; next start a=15,b=0 -> diff=0xF.
REQ-033 start held high for 20 cycles -> done every 6 cycles, results consistent with held operands.

Source files
------------

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor computing a - b as a + ~b + 1, LSB first
//
// Purpose : one full-adder bit per clock; result and borrow are published on the
//           edge that enters DONE and held until the next completion.
// Ports   : clk    - rising-edge clock
//           rst    - synchronous active-high reset
//           start  - request; accepted only in IDLE
//           a, b   - operands, captured on the accepting edge
//           busy   - high while bits are being processed (RUN)
//           done   - one-cycle result-valid pulse (DONE)
//           diff   - a - b mod 2^WIDTH
//           b_out  - borrow out, 1 iff a < b unsigned
//           zero   - diff == 0             (SERIAL_SUB_FLAGS_EN only)
//           ovf    - signed overflow flag  (SERIAL_SUB_FLAGS_EN only)
// Config  : define SERIAL_SUB_FLAGS_EN to add the zero/ovf outputs.

module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic             b_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] nb_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             zero_q;
    logic             ovf_q;
`endif

    logic             sum_d;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;
    logic             last_bit;

    // One full-adder slice; the sum bit enters the result at the MSB so that after
    // WIDTH shifts the first (LSB) sum bit has reached bit 0.
    always_comb begin
        sum_d    = a_sh_q[0] ^ nb_sh_q[0] ^ carry_q;
        carry_d  = (a_sh_q[0] & nb_sh_q[0]) | (carry_q & (a_sh_q[0] ^ nb_sh_q[0]));
        res_d    = {sum_d, res_q[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            nb_sh_q <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        nb_sh_q <= ~b;
                        cnt_q   <= '0;
                        carry_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef SERIAL_SUB_FLAGS_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    nb_sh_q <= nb_sh_q >> 1;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        b_out_q <= ~carry_d;
                        state_q <= DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                        zero_q  <= (res_d == '0);
                        ovf_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign b_out = b_out_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign zero  = zero_q;
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - randomized and directed self-checking bench for serial_sub

module tb_serial_sub;

    localparam int W   = 4;
    localparam int MOD = 1 << W;
    localparam int LIM = 1 << (W - 1);

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_FLAGS_EN
        .zero  (zero),
        .ovf   (ovf),
`endif
        .b_out (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: transaction-level view. An accepted operation finishes
    // WIDTH edges later; the unit is free again WIDTH+2 edges after acceptance.
    int edge_n;
    int next_free;
    int done_edge;
    bit pending;
    int op_a;
    int op_b;
    int exp_diff;
    int exp_bout;
    int exp_zero;
    int exp_ovf;
    int exp_busy;
    int exp_done;

    // Observations for directed scenarios.
    int done_cnt;
    int busy_cnt;
    int last_diff;
    int last_bout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= LIM) ? v - MOD : v;
    endfunction

    task automatic model_edge();
        int sr;
        exp_done = 0;
        if (rst) begin
            pending   = 0;
            next_free = edge_n + 1;
            exp_diff  = 0;
            exp_bout  = 0;
            exp_zero  = 0;
            exp_ovf   = 0;
        end else begin
            if (pending && edge_n == done_edge) begin
                pending  = 0;
                exp_done = 1;
                exp_diff = (op_a - op_b + MOD) % MOD;
                exp_bout = (op_a < op_b) ? 1 : 0;
                exp_zero = (exp_diff == 0) ? 1 : 0;
                sr       = to_signed(op_a) - to_signed(op_b);
                exp_ovf  = (sr >= LIM || sr < -LIM) ? 1 : 0;
            end
            if (start && !pending && edge_n >= next_free) begin
                pending   = 1;
                op_a      = int'(a);
                op_b      = int'(b);
                done_edge = edge_n + W;
                next_free = edge_n + W + 2;
            end
        end
        exp_busy = pending ? 1 : 0;
    endtask

    // One clock: the model sees the inputs the DUT samples, outputs are compared
    // 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("busy",  32'(busy),  32'(exp_busy));
        check("done",  32'(done),  32'(exp_done));
        check("diff",  32'(diff),  32'(exp_diff));
        check("b_out", 32'(b_out), 32'(exp_bout));
        check("busy_done_excl", 32'(busy & done), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
        check("zero", 32'(zero), 32'(exp_zero));
        check("ovf",  32'(ovf),  32'(exp_ovf));
`endif
        if (done) begin
            done_cnt++;
            last_diff = int'(diff);
            last_bout = int'(b_out);
        end
        if (busy) busy_cnt++;
        edge_n++;
    endtask

    task automatic clear_obs();
        done_cnt  = 0;
        busy_cnt  = 0;
        last_diff = -1;
        last_bout = -1;
    endtask

    // Pulse start for one edge with the given operands, then idle long enough
    // for the operation to finish and the unit to return to IDLE.
    task automatic run_op(input int va, input int vb);
        clear_obs();
        start = 1'b1;
        a     = W'(va);
        b     = W'(vb);
        step();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        for (int i = 0; i < W + 3; i++) step();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        edge_n    = 0;
        next_free = 0;
        done_edge = -1;
        pending   = 0;
        op_a      = 0;
        op_b      = 0;
        exp_diff  = 0;
        exp_bout  = 0;
        exp_zero  = 0;
        exp_ovf   = 0;
        exp_busy  = 0;
        exp_done  = 0;
        clear_obs();

        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd1;
        step();
        step();
        rst   = 1'b0;
        start = 1'b0;
        step();

        // a=7, b=3: busy for exactly WIDTH cycles
        run_op(7, 3);
        check("r028_diff", 32'(last_diff), 32'd4);
        check("r028_bout", 32'(last_bout), 32'd0);
        check("r028_busy_cycles", 32'(busy_cnt), 32'(W));
        check("r028_done_cnt", 32'(done_cnt), 32'd1);

        run_op(3, 7);
        check("r029_diff", 32'(last_diff), 32'hC);
        check("r029_bout", 32'(last_bout), 32'd1);

        run_op(7, 8);
        check("r030a_diff", 32'(last_diff), 32'hF);
        check("r030a_bout", 32'(last_bout), 32'd1);

        run_op(5, 5);
        check("r030b_diff", 32'(last_diff), 32'd0);
        check("r030b_bout", 32'(last_bout), 32'd0);

        // start pulse during RUN is ignored, operands changing mid-run have no effect
        clear_obs();
        start = 1'b1; a = 4'd9; b = 4'd2;
        step();
        start = 1'b0;
        step();
        start = 1'b1; a = 4'd1; b = 4'd1;
        step();
        start = 1'b0; a = 4'd0; b = 4'd15;
        for (int i = 0; i < 2 * W + 4; i++) step();
        check("r031_diff", 32'(last_diff), 32'd7);
        check("r031_done_cnt", 32'(done_cnt), 32'd1);

        // reset on 3rd RUN cycle aborts
        clear_obs();
        start = 1'b1; a = 4'd12; b = 4'd3;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < W + 3; i++) step();
        check("r032_no_done", 32'(done_cnt), 32'd0);
        check("r032_diff_cleared", 32'(diff), 32'd0);
        run_op(15, 0);
        check("r032_restart_diff", 32'(last_diff), 32'hF);

        // start held high: one result every WIDTH+2 cycles
        clear_obs();
        start = 1'b1; a = 4'd2; b = 4'd9;
        for (int i = 0; i < 20; i++) step();
        start = 1'b0;
        for (int i = 0; i < W + 3; i++) step();
        check("r033_done_cnt", 32'(done_cnt), 32'd4);
        check("r033_diff", 32'(last_diff), 32'd9);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            step();
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < W + 3; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
